maxnet_controller: RTL and testbench
====================================

// Module: maxnet_controller
// PURPOSE
//  Sequencing FSM for the MaxNet datapath. Pulses the input-memory load, seeds the
//  neuron registers, then repeats inhibition updates until at most one neuron stays
//  positive. Reports the winner index and an iteration count.
//  Sits between the top-level start/done handshake and the memory/neuron-register/
//  inhibition datapath.
// PARAMETERS
//  N         4   number of neurons; must match the memory depth (4 x 32-bit words).
//  CALC_LAT  1   datapath cycles per inhibition step, >=1. Gap between reg_ld pulses.
//  ITER_W    8   width of iter_cnt.
//  MAX_ITER  200 iteration cap, used only with MAXNET_TIMEOUT_EN.
// PORTS
//  clk         in   1              rising-edge clock
//  rst         in   1              asynchronous reset, active-high
//  start       in   1              level request; sampled in IDLE only
//  pos_flags   in   N              bit i = 1 when neuron register i > 0
//  mem_ld      out  1              one-cycle load pulse to the input memory
//  init_sel    out  1              1 = neuron regs take memory words; 0 = take inhibition results
//  reg_ld      out  1              neuron register write enable
//  busy        out  1              high from LOAD through CALC
//  done        out  1              high while in DONE
//  winner_vld  out  1              1 = exactly one pos_flags bit set at completion
//  winner_idx  out  $clog2(N)      index of the surviving neuron; valid with winner_vld
//  iter_cnt    out  ITER_W         completed inhibition steps; saturates at all-ones
//  timeout     out  1              iteration cap hit (tied 0 without the macro)
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE. Every output 0, including counters and winner_idx.
//  - IDLE: all strobes 0. If start=1, go to LOAD next cycle.
//  - LOAD, 1 cycle: mem_ld=1. Then go to INIT.
//  - INIT, 1 cycle: init_sel=1, reg_ld=1. Clear iter_cnt and the wait counter. Then go to CALC.
//  - CALC:
//      * The wait counter counts 0..CALC_LAT-1.
//      * On the cycle the count reaches CALC_LAT-1, evaluate pos_flags:
//          - popcount<=1: go to DONE with no reg_ld. Latch winner_vld=(popcount==1).
//            Latch winner_idx = index of the set bit, or 0 when none is set.
//          - otherwise: reg_ld=1 (init_sel=0), iter_cnt+=1, wait counter back to 0.
//      * No flag evaluation on other CALC cycles.
//  - DONE: done=1; winner and iter_cnt outputs held. Go to IDLE when start=0.
//    start held high does not retrigger.
//  - pos_flags=0 at the first evaluation (all inputs <=0): DONE after 0 iterations,
//    winner_vld=0.
//  - Ties that drive every neuron to 0 in the same step give the same result
//    (winner_vld=0).
//  - winner_idx/winner_vld/timeout are cleared on leaving IDLE toward LOAD.
//  - Latency for an already-decided input: start -> done = 3 + CALC_LAT cycles.
//  - reg_ld is never asserted in IDLE, LOAD or DONE. mem_ld is only asserted in LOAD.
// CONFIGURATION
//  MAXNET_TIMEOUT_EN
//   - defined: in CALC, when iter_cnt==MAX_ITER at an evaluation point and popcount>1,
//     go to DONE with timeout=1, winner_vld=0. timeout is held until leaving IDLE again.
//   - undefined: no cap; iteration continues until convergence. timeout is constant 0.
// STRUCTURE
//  - Package maxnet_pkg: N default; state enum {IDLE, LOAD, INIT, CALC, DONE} (3-bit binary).
//  - Sub-module maxnet_winner_enc (combinational, N-input): pos_flags ->
//    {le_one = popcount<=1, one = popcount==1, idx}.
//  - Controller: state register, wait counter, iter counter, winner latch only.
// TESTING
//  1. Assert rst mid-CALC -> next cycle every output is 0, state IDLE.
//     Start after release -> mem_ld pulse.
//  2. CALC_LAT=1, pos_flags forced 4'b1111 for 3 evals then 4'b0100 -> reg_ld x3,
//     iter_cnt=3, done, winner_vld=1, winner_idx=2.
//  3. pos_flags=4'b0000 at first eval -> done at cycle 4 after start, iter_cnt=0,
//     winner_vld=0.
//  4. CALC_LAT=3, flags 4'b1010 for 2 evals then 4'b1000 -> reg_ld pulses 3 cycles
//     apart, winner_idx=3.
//  5. Hold start high through DONE -> stays DONE. Drop start -> IDLE.
//     Raise start -> new LOAD, outputs cleared.
//  6. MAXNET_TIMEOUT_EN with MAX_ITER=5, flags stuck 4'b0011 -> done with timeout=1,
//     iter_cnt=5. Without the macro -> still busy after 50 evals.

Source files
------------

// File: rtl/maxnet_pkg.sv
// Shared types and constants for the MaxNet sequencing controller.
// The state encoding is plain 3-bit binary so older tooling can decode it.
package maxnet_pkg;

    localparam int unsigned N_DEFAULT = 4;

    typedef logic [2:0] state_t;

    localparam state_t StIdle = 3'd0;
    localparam state_t StLoad = 3'd1;
    localparam state_t StInit = 3'd2;
    localparam state_t StCalc = 3'd3;
    localparam state_t StDone = 3'd4;

    // Index width that stays legal for a single-neuron build.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/maxnet_winner_enc.sv
// Combinational survivor encoder: classifies the positive-flag vector and reports
// whether at most one / exactly one neuron is still positive, plus its index.
module maxnet_winner_enc
    import maxnet_pkg::*;
#(
    parameter int unsigned N = N_DEFAULT,
    localparam int unsigned IDX_W = idx_width(N)
) (
    input  logic [N-1:0]     flags,
    output logic             le_one,
    output logic             one,
    output logic [IDX_W-1:0] idx
);

    localparam int unsigned CNT_W = $clog2(N + 1);

    logic [CNT_W-1:0] cnt;

    always_comb begin
        cnt = '0;
        idx = '0;
        for (int i = 0; i < N; i++) begin
            cnt = cnt + CNT_W'(flags[i]);
        end
        // Scan downward so the lowest set bit wins; only meaningful when one bit is set.
        for (int i = N - 1; i >= 0; i--) begin
            if (flags[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

    assign le_one = (cnt <= CNT_W'(1));
    assign one    = (cnt == CNT_W'(1));

endmodule

// File: rtl/maxnet_controller.sv
// MaxNet sequencing FSM: load memory, seed neuron registers, iterate inhibition
// until at most one neuron stays positive. Optional iteration cap: MAXNET_TIMEOUT_EN.
module maxnet_controller
    import maxnet_pkg::*;
#(
    parameter int unsigned N        = N_DEFAULT,
    parameter int unsigned CALC_LAT = 1,
    parameter int unsigned ITER_W   = 8,
    parameter int unsigned MAX_ITER = 200,
    localparam int unsigned IDX_W   = idx_width(N)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [N-1:0]      pos_flags,
    output logic              mem_ld,
    output logic              init_sel,
    output logic              reg_ld,
    output logic              busy,
    output logic              done,
    output logic              winner_vld,
    output logic [IDX_W-1:0]  winner_idx,
    output logic [ITER_W-1:0] iter_cnt,
    output logic              timeout
);

    localparam int unsigned WAIT_W = (CALC_LAT > 1) ? $clog2(CALC_LAT) : 1;

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [ITER_W-1:0] iter_q, iter_d;
    logic              wvld_q, wvld_d;
    logic [IDX_W-1:0]  widx_q, widx_d;
    logic              eval;
    logic              step;
    logic              at_cap;
    logic              le_one;
    logic              one;
    logic [IDX_W-1:0]  idx;

    maxnet_winner_enc #(
        .N (N)
    ) u_winner_enc (
        .flags  (pos_flags),
        .le_one (le_one),
        .one    (one),
        .idx    (idx)
    );

    assign eval   = (wait_q == WAIT_W'(CALC_LAT - 1));
    assign at_cap = (iter_q == ITER_W'(MAX_ITER));

`ifdef MAXNET_TIMEOUT_EN
    logic tmo_q, tmo_d;
`else
    logic unused_at_cap;
    assign unused_at_cap = at_cap;
`endif

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        iter_d  = iter_q;
        wvld_d  = wvld_q;
        widx_d  = widx_q;
        step    = 1'b0;
`ifdef MAXNET_TIMEOUT_EN
        tmo_d   = tmo_q;
`endif
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StLoad;
                    wvld_d  = 1'b0;
                    widx_d  = '0;
`ifdef MAXNET_TIMEOUT_EN
                    tmo_d   = 1'b0;
`endif
                end
            end
            StLoad: state_d = StInit;
            StInit: begin
                state_d = StCalc;
                iter_d  = '0;
                wait_d  = '0;
            end
            StCalc: begin
                if (!eval) begin
                    wait_d = wait_q + WAIT_W'(1);
                end else if (le_one) begin
                    state_d = StDone;
                    wvld_d  = one;
                    widx_d  = idx;
`ifdef MAXNET_TIMEOUT_EN
                end else if (at_cap) begin
                    state_d = StDone;
                    wvld_d  = 1'b0;
                    tmo_d   = 1'b1;
`endif
                end else begin
                    step   = 1'b1;
                    wait_d = '0;
                    if (iter_q != '1) begin
                        iter_d = iter_q + ITER_W'(1);
                    end
                end
            end
            StDone: begin
                if (!start) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            wait_q  <= '0;
            iter_q  <= '0;
            wvld_q  <= 1'b0;
            widx_q  <= '0;
`ifdef MAXNET_TIMEOUT_EN
            tmo_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            iter_q  <= iter_d;
            wvld_q  <= wvld_d;
            widx_q  <= widx_d;
`ifdef MAXNET_TIMEOUT_EN
            tmo_q   <= tmo_d;
`endif
        end
    end

    always_comb begin
        mem_ld   = (state_q == StLoad);
        init_sel = (state_q == StInit);
        reg_ld   = (state_q == StInit) | step;
        busy     = (state_q == StLoad) | (state_q == StInit) | (state_q == StCalc);
        done     = (state_q == StDone);
    end

    assign winner_vld = wvld_q;
    assign winner_idx = widx_q;
    assign iter_cnt   = iter_q;
`ifdef MAXNET_TIMEOUT_EN
    assign timeout = tmo_q;
`else
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_maxnet_controller.sv
// Bench for maxnet_controller: two instances (CALC_LAT 1 and 3) driven by directed and
// random flag sequences, checked cycle by cycle against a timeline model.
module tb_maxnet_controller;

    localparam int unsigned MAX_ITER = 5;
    localparam int LAT[2] = '{1, 3};

    logic       clk;
    logic       rst;
    logic       start_a  [2];
    logic [3:0] flags_a  [2];
    logic       mem_ld_a [2];
    logic       isel_a   [2];
    logic       reg_ld_a [2];
    logic       busy_a   [2];
    logic       done_a   [2];
    logic       wvld_a   [2];
    logic [1:0] widx_a   [2];
    logic [7:0] iter_a   [2];
    logic       tmo_a    [2];

    int n_cmp = 0;
    int n_err = 0;

    maxnet_controller #(
        .N(4), .CALC_LAT(1), .ITER_W(8), .MAX_ITER(MAX_ITER)
    ) u_dut_lat1 (
        .clk(clk), .rst(rst), .start(start_a[0]), .pos_flags(flags_a[0]),
        .mem_ld(mem_ld_a[0]), .init_sel(isel_a[0]), .reg_ld(reg_ld_a[0]),
        .busy(busy_a[0]), .done(done_a[0]), .winner_vld(wvld_a[0]),
        .winner_idx(widx_a[0]), .iter_cnt(iter_a[0]), .timeout(tmo_a[0])
    );

    maxnet_controller #(
        .N(4), .CALC_LAT(3), .ITER_W(8), .MAX_ITER(MAX_ITER)
    ) u_dut_lat3 (
        .clk(clk), .rst(rst), .start(start_a[1]), .pos_flags(flags_a[1]),
        .mem_ld(mem_ld_a[1]), .init_sel(isel_a[1]), .reg_ld(reg_ld_a[1]),
        .busy(busy_a[1]), .done(done_a[1]), .winner_vld(wvld_a[1]),
        .winner_idx(widx_a[1]), .iter_cnt(iter_a[1]), .timeout(tmo_a[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // {mem_ld, init_sel, reg_ld, busy, done}
    function automatic logic [4:0] strobes(input int d);
        return {mem_ld_a[d], isel_a[d], reg_ld_a[d], busy_a[d], done_a[d]};
    endfunction

    function automatic logic [16:0] all_outs(input int d);
        return {strobes(d), wvld_a[d], tmo_a[d], widx_a[d], iter_a[d]};
    endfunction

    function automatic logic [3:0] at_most_one();
        int r;
        r = $urandom_range(0, 4);
        return (r == 0) ? 4'b0000 : 4'(1 << (r - 1));
    endfunction

    // Drives one start..done..idle transaction; fl[j] is the flag vector seen at evaluation j.
    task automatic run_txn(input int d, input logic [3:0] fl[$]);
        int lat, e, pc, last_c, j;
        logic vld, tmo, ev, exp_rl;
        logic [1:0] idx;
        lat = LAT[d];
        e = 0; vld = 1'b0; tmo = 1'b0; idx = 2'd0;
        for (int k = 0; k < fl.size(); k++) begin
            pc = $countones(fl[k]);
            if (pc <= 1) begin
                e = k + 1;
                vld = (pc == 1);
                for (int b = 3; b >= 0; b--) if (fl[k][b]) idx = 2'(b);
                break;
            end
`ifdef MAXNET_TIMEOUT_EN
            if (k == MAX_ITER) begin
                e = k + 1;
                tmo = 1'b1;
                break;
            end
`endif
        end
        if (e == 0) begin
            check_eq("model_list_unterminated", 32'(fl.size()), 32'(0));
            return;
        end
        last_c = 2 + e * lat;

        @(negedge clk);
        start_a[d] = 1'b1;
        flags_a[d] = 4'($urandom);
        #1 check_eq("idle_strobes", 32'(strobes(d)), 32'(0));
        for (int c = 1; c <= last_c + 1; c++) begin
            @(negedge clk);
            j  = (c - 3) / lat;
            ev = 1'b0;
            if (c >= 3 && c <= last_c) begin
                ev = ((c - 2) % lat) == 0;
                flags_a[d] = ev ? fl[j] : at_most_one();
            end else begin
                flags_a[d] = 4'($urandom);
            end
            #1;
            if (c == 1) begin
                check_eq("load_strobes", 32'(strobes(d)), 32'(5'b10010));
            end else if (c == 2) begin
                check_eq("init_strobes", 32'(strobes(d)), 32'(5'b01110));
            end else if (c <= last_c) begin
                exp_rl = ev && (j < e - 1);
                check_eq("calc_strobes", 32'(strobes(d)), 32'({3'b000, 2'b10} | {2'b00, exp_rl, 2'b00}));
                check_eq("calc_iter", 32'(iter_a[d]), 32'(j));
            end else begin
                check_eq("done_strobes", 32'(strobes(d)), 32'(5'b00001));
                check_eq("done_iter", 32'(iter_a[d]), 32'(e - 1));
                check_eq("done_winner", 32'({tmo_a[d], wvld_a[d], widx_a[d]}),
                         32'({tmo, vld, idx}));
            end
            if (c < last_c + 1) begin
                check_eq("winner_cleared", 32'({tmo_a[d], wvld_a[d], widx_a[d]}), 32'(0));
            end
        end
        // start still high: must stay in DONE
        repeat ($urandom_range(1, 3)) begin
            @(negedge clk);
            #1 check_eq("done_hold", 32'(strobes(d)), 32'(5'b00001));
        end
        @(negedge clk);
        start_a[d] = 1'b0;
        @(negedge clk);
        #1;
        check_eq("back_idle", 32'(strobes(d)), 32'(0));
        check_eq("idle_keeps_result", 32'({tmo_a[d], wvld_a[d], widx_a[d], iter_a[d]}),
                 32'({tmo, vld, idx, 8'(e - 1)}));
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [3:0] q[$];
        int len;
        logic [3:0] v;

        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            start_a[d] = 1'b0;
            flags_a[d] = 4'b0000;
        end
        repeat (2) @(negedge clk);
        #1;
        for (int d = 0; d < 2; d++) check_eq("reset_outputs", 32'(all_outs(d)), 32'(0));
        rst = 1'b0;

        // Reset asserted in the middle of CALC.
        @(negedge clk);
        start_a[0] = 1'b1;
        flags_a[0] = 4'b1111;
        repeat (5) @(negedge clk);
        check_eq("pre_reset_busy", 32'(busy_a[0]), 32'(1));
        rst = 1'b1;
        #1 check_eq("async_reset_outputs", 32'(all_outs(0)), 32'(0));
        @(negedge clk);
        check_eq("reset_held_outputs", 32'(all_outs(0)), 32'(0));
        rst = 1'b0;
        start_a[0] = 1'b0;
        q = '{4'b0001};
        run_txn(0, q);

        q = '{4'b1111, 4'b1111, 4'b1111, 4'b0100};
        run_txn(0, q);
        q = '{4'b0000};
        run_txn(0, q);
        q = '{4'b1010, 4'b1010, 4'b1000};
        run_txn(1, q);

        // Flags stuck with two positive neurons.
`ifdef MAXNET_TIMEOUT_EN
        q = {};
        for (int k = 0; k < 60; k++) q.push_back(4'b0011);
        run_txn(0, q);
`else
        @(negedge clk);
        start_a[0] = 1'b1;
        flags_a[0] = 4'b0011;
        repeat (53) @(negedge clk);
        #1;
        check_eq("no_cap_busy", 32'(busy_a[0]), 32'(1));
        check_eq("no_cap_iter", 32'(iter_a[0]), 32'(50));
        check_eq("no_cap_timeout", 32'(tmo_a[0]), 32'(0));
        start_a[0] = 1'b0;
        pulse_reset();
`endif

        for (int t = 0; t < 24; t++) begin
            q = {};
            len = $urandom_range(1, 7);
            for (int k = 0; k < len - 1; k++) begin
                do v = 4'($urandom); while ($countones(v) < 2);
                q.push_back(v);
            end
            q.push_back(at_most_one());
            run_txn(int'($urandom_range(0, 1)), q);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
